// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle controller and the ALU.
// State, ALU-op, operand-select and PC-source encodings live here so every user agrees.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_AND = 3'b001,
    ALU_XOR = 3'b010,
    ALU_SUB = 3'b100,
    ALU_OR  = 3'b101,
    ALU_LUI = 3'b110
  } alu_op_t;

  typedef enum logic [1:0] {
    SRC_B_REG  = 2'b00,
    SRC_B_FOUR = 2'b01,
    SRC_B_SEXT = 2'b10,
    SRC_B_ZEXT = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PC_SRC_ALU     = 2'b00,
    PC_SRC_ALU_OUT = 2'b01,
    PC_SRC_JUMP    = 2'b10
  } pc_src_t;

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_LOAD,
    CLS_STORE,
    CLS_ALU_IMM,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_ILLEGAL
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;

  typedef struct packed {
    alu_op_t    alu_op;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    pc_src_t    pc_src;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       iord;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Successor of DECODE for each instruction class.
  function automatic state_t exec_state(instr_class_t cls);
    case (cls)
      CLS_RTYPE:   return S_R_EXEC;
      CLS_LOAD:    return S_MEM_ADDR;
      CLS_STORE:   return S_MEM_ADDR;
      CLS_ALU_IMM: return S_I_EXEC;
      CLS_BRANCH:  return S_BRANCH;
      CLS_JUMP:    return S_JUMP;
      default:     return S_HALT;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, strobes and selects out.
interface multicycle_ctrl_if;
  import multicycle_ctrl_pkg::*;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  alu_op_t    alu_op;
  logic       alu_src_a;
  alu_src_b_t alu_src_b;
  pc_src_t    pc_src;
  logic       pc_write;
  logic       pc_write_cond;
  logic       pc_en;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       iord;
  logic       illegal;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output alu_op, alu_src_a, alu_src_b, pc_src, pc_write, pc_write_cond, pc_en,
           ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, iord,
           illegal, state_dbg
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, pc_src, pc_write, pc_write_cond, pc_en,
           ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, iord,
           illegal, state_dbg
  );
endinterface

// File: rtl/multicycle_ctrl_alu_op_decode.sv
// Combinational instruction decode: opcode -> class and immediate ALU setup,
// funct -> R-type ALU op and legality.
module alu_op_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0]   i_opcode,
  input  logic [5:0]   i_funct,
  output instr_class_t o_cls,
  output alu_op_t      o_imm_alu_op,
  output alu_src_b_t   o_imm_alu_src_b,
  output alu_op_t      o_r_alu_op,
  output logic         o_r_legal
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    o_cls           = CLS_ILLEGAL;
    o_imm_alu_op    = ALU_ADD;
    o_imm_alu_src_b = SRC_B_SEXT;
    case (i_opcode)
      OP_RTYPE: o_cls = CLS_RTYPE;
      OP_LW:    o_cls = CLS_LOAD;
      OP_SW:    o_cls = CLS_STORE;
      OP_BEQ:   o_cls = CLS_BRANCH;
      OP_J:     o_cls = CLS_JUMP;
      OP_ADDI:  o_cls = CLS_ALU_IMM;
      OP_ANDI: begin
        o_cls           = CLS_ALU_IMM;
        o_imm_alu_op    = ALU_AND;
        o_imm_alu_src_b = SRC_B_ZEXT;
      end
      OP_ORI: begin
        o_cls           = CLS_ALU_IMM;
        o_imm_alu_op    = ALU_OR;
        o_imm_alu_src_b = SRC_B_ZEXT;
      end
      OP_XORI: begin
        o_cls           = CLS_ALU_IMM;
        o_imm_alu_op    = ALU_XOR;
        o_imm_alu_src_b = SRC_B_ZEXT;
      end
      OP_LUI: begin
        o_cls        = CLS_ALU_IMM;
        o_imm_alu_op = ALU_LUI;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_r_alu_op = ALU_ADD;
    o_r_legal  = 1'b1;
    case (i_funct)
      FN_ADD:  o_r_alu_op = ALU_ADD;
      FN_SUB:  o_r_alu_op = ALU_SUB;
      FN_AND:  o_r_alu_op = ALU_AND;
      FN_OR:   o_r_alu_op = ALU_OR;
      FN_XOR:  o_r_alu_op = ALU_XOR;
      default: o_r_legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM: state register, sticky illegal flag and
// Moore output decode of the current state.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  multicycle_ctrl_if.master bus
);

  state_t       r_state;
  state_t       w_next_state;
  logic         r_illegal;
  logic         r_is_store;
  alu_op_t      r_imm_alu_op;
  alu_src_b_t   r_imm_alu_src_b;

  instr_class_t w_cls;
  alu_op_t      w_imm_alu_op;
  alu_src_b_t   w_imm_alu_src_b;
  alu_op_t      w_r_alu_op;
  logic         w_r_legal;
  ctrl_t        w_ctrl;

  alu_op_decode u_alu_op_decode (
    .i_opcode        (bus.opcode),
    .i_funct         (bus.funct),
    .o_cls           (w_cls),
    .o_imm_alu_op    (w_imm_alu_op),
    .o_imm_alu_src_b (w_imm_alu_src_b),
    .o_r_alu_op      (w_r_alu_op),
    .o_r_legal       (w_r_legal)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:    if (bus.mem_ready) w_next_state = S_DECODE;
      S_DECODE:   w_next_state = exec_state(w_cls);
      S_MEM_ADDR: w_next_state = r_is_store ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (bus.mem_ready) w_next_state = S_MEM_WB;
      S_MEM_WR:   if (bus.mem_ready) w_next_state = S_FETCH;
      S_R_EXEC:   w_next_state = w_r_legal ? S_R_WB : S_HALT;
      S_I_EXEC:   w_next_state = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP:
                  w_next_state = S_FETCH;
      S_HALT:     w_next_state = S_HALT;
      default:    w_next_state = S_FETCH;
    endcase
  end

  // The opcode is only valid during DECODE, so the facts later states need are captured then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_FETCH;
      r_illegal       <= 1'b0;
      r_is_store      <= 1'b0;
      r_imm_alu_op    <= ALU_ADD;
      r_imm_alu_src_b <= SRC_B_REG;
    end else begin
      // NOTE: non-blocking everywhere here so every flop updates from pre-edge values.
      r_state <= w_next_state;
      if (w_next_state == S_HALT) r_illegal <= 1'b1;
      if (r_state == S_DECODE) begin
        r_is_store      <= (w_cls == CLS_STORE);
        r_imm_alu_op    <= w_imm_alu_op;
        r_imm_alu_src_b <= w_imm_alu_src_b;
      end
    end
  end

  always_comb begin
    w_ctrl = CTRL_IDLE;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = SRC_B_FOUR;
        w_ctrl.ir_write  = bus.mem_ready;
        w_ctrl.pc_write  = bus.mem_ready;
      end
      S_DECODE: w_ctrl.alu_src_b = SRC_B_SEXT;
      S_MEM_ADDR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRC_B_SEXT;
      end
      S_MEM_RD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.iord     = 1'b1;
      end
      S_MEM_WR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.iord      = 1'b1;
      end
      S_MEM_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
      end
      S_R_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRC_B_REG;
        w_ctrl.alu_op    = w_r_alu_op;
      end
      S_R_WB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
      end
      S_I_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = r_imm_alu_src_b;
        w_ctrl.alu_op    = r_imm_alu_op;
      end
      S_I_WB: w_ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_src_b     = SRC_B_REG;
        w_ctrl.alu_op        = ALU_SUB;
        w_ctrl.pc_src        = PC_SRC_ALU_OUT;
        w_ctrl.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        w_ctrl.pc_write = 1'b1;
        w_ctrl.pc_src   = PC_SRC_JUMP;
      end
      default: ;
    endcase
    // FETCH is state zero, so strobes must also be forced off while reset is held.
    if (!rst_n) w_ctrl = CTRL_IDLE;
  end

  assign bus.alu_op        = w_ctrl.alu_op;
  assign bus.alu_src_a     = w_ctrl.alu_src_a;
  assign bus.alu_src_b     = w_ctrl.alu_src_b;
  assign bus.pc_src        = w_ctrl.pc_src;
  assign bus.pc_write      = w_ctrl.pc_write;
  assign bus.pc_write_cond = w_ctrl.pc_write_cond;
  assign bus.pc_en         = w_ctrl.pc_write | (w_ctrl.pc_write_cond & bus.zero);
  assign bus.ir_write      = w_ctrl.ir_write;
  assign bus.mem_read      = w_ctrl.mem_read;
  assign bus.mem_write     = w_ctrl.mem_write;
  assign bus.reg_write     = w_ctrl.reg_write;
  assign bus.reg_dst       = w_ctrl.reg_dst;
  assign bus.mem_to_reg    = w_ctrl.mem_to_reg;
  assign bus.iord          = w_ctrl.iord;
  assign bus.illegal       = r_illegal;
  assign bus.state_dbg     = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected outputs are queued by the
// stimulus and compared by an independent monitor on the falling edge.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  multicycle_ctrl_if bus();

  multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [22:0] exp;
  } sb_t;

  sb_t q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  localparam logic [5:0] GOP = 6'b111111;
  localparam logic [5:0] GFN = 6'b000000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [22:0] got, input logic [22:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%06h, expected 0x%06h", name, got, exp);
    end
  endtask

  // {alu_op, src_a, src_b, pc_src, strobes, pc_en, illegal, state}
  // strobes = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, iord}
  function automatic logic [22:0] vec(input logic [2:0] op, input logic a, input logic [1:0] b,
                                      input logic [1:0] ps, input logic [8:0] stb,
                                      input logic pen, input logic ill, input state_t st);
    return {op, a, b, ps, stb, pen, ill, st};
  endfunction

  function automatic logic [22:0] observed();
    return {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.pc_src,
            bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.mem_read, bus.mem_write,
            bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.iord,
            bus.pc_en, bus.illegal, bus.state_dbg};
  endfunction

  function automatic logic [22:0] e_fetch(input logic rdy);
    return vec(3'b000, 1'b0, 2'b01, 2'b00, rdy ? 9'b101100000 : 9'b000100000, rdy, 1'b0, S_FETCH);
  endfunction
  function automatic logic [22:0] e_decode();
    return vec(3'b000, 1'b0, 2'b10, 2'b00, 9'b000000000, 1'b0, 1'b0, S_DECODE);
  endfunction
  function automatic logic [22:0] e_r_exec(input logic [2:0] op);
    return vec(op, 1'b1, 2'b00, 2'b00, 9'b000000000, 1'b0, 1'b0, S_R_EXEC);
  endfunction
  function automatic logic [22:0] e_r_wb();
    return vec(3'b000, 1'b0, 2'b00, 2'b00, 9'b000001100, 1'b0, 1'b0, S_R_WB);
  endfunction
  function automatic logic [22:0] e_mem_addr();
    return vec(3'b000, 1'b1, 2'b10, 2'b00, 9'b000000000, 1'b0, 1'b0, S_MEM_ADDR);
  endfunction
  function automatic logic [22:0] e_mem_rd();
    return vec(3'b000, 1'b0, 2'b00, 2'b00, 9'b000100001, 1'b0, 1'b0, S_MEM_RD);
  endfunction
  function automatic logic [22:0] e_mem_wb();
    return vec(3'b000, 1'b0, 2'b00, 2'b00, 9'b000001010, 1'b0, 1'b0, S_MEM_WB);
  endfunction
  function automatic logic [22:0] e_mem_wr();
    return vec(3'b000, 1'b0, 2'b00, 2'b00, 9'b000010001, 1'b0, 1'b0, S_MEM_WR);
  endfunction
  function automatic logic [22:0] e_i_exec(input logic [2:0] op, input logic [1:0] b);
    return vec(op, 1'b1, b, 2'b00, 9'b000000000, 1'b0, 1'b0, S_I_EXEC);
  endfunction
  function automatic logic [22:0] e_i_wb();
    return vec(3'b000, 1'b0, 2'b00, 2'b00, 9'b000001000, 1'b0, 1'b0, S_I_WB);
  endfunction
  function automatic logic [22:0] e_branch(input logic z);
    return vec(3'b100, 1'b1, 2'b00, 2'b01, 9'b010000000, z, 1'b0, S_BRANCH);
  endfunction
  function automatic logic [22:0] e_jump();
    return vec(3'b000, 1'b0, 2'b00, 2'b10, 9'b100000000, 1'b1, 1'b0, S_JUMP);
  endfunction
  function automatic logic [22:0] e_halt();
    return vec(3'b000, 1'b0, 2'b00, 2'b00, 9'b000000000, 1'b0, 1'b1, S_HALT);
  endfunction

  // One clock cycle: drive inputs, queue this cycle's expected outputs, advance.
  task automatic cyc(input string name, input logic rdy, input logic [5:0] op,
                     input logic [5:0] fn, input logic z, input logic [22:0] exp);
    sb_t e;
    bus.mem_ready = rdy;
    bus.opcode    = op;
    bus.funct     = fn;
    bus.zero      = z;
    e.name = name;
    e.exp  = exp;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 with the scoreboard empty; leaves the DUT idling in FETCH.
  task automatic do_reset(input string name);
    rst_n = 1'b0;
    #1;
    check(name, observed(), 23'h0);
    bus.mem_ready = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    sb_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check(e.name, observed(), e.exp);
      end
    end
  end

  initial begin : stimulus
    rst_n         = 1'b0;
    bus.opcode    = GOP;
    bus.funct     = GFN;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    #2;
    check("reset_outputs", observed(), 23'h0);
    bus.mem_ready = 1'b0;
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // add: 4 cycles, funct garbage during DECODE must be ignored
    cyc("add_fetch",   1'b1, GOP,       GFN,       1'b1, e_fetch(1'b1));
    cyc("add_decode",  1'b1, 6'b000000, 6'b111111, 1'b1, e_decode());
    cyc("add_rexec",   1'b1, GOP,       6'b100000, 1'b1, e_r_exec(3'b000));
    cyc("add_rwb",     1'b1, GOP,       GFN,       1'b1, e_r_wb());
    // sub and xor
    cyc("sub_fetch",   1'b1, GOP,       GFN,       1'b1, e_fetch(1'b1));
    cyc("sub_decode",  1'b1, 6'b000000, GFN,       1'b1, e_decode());
    cyc("sub_rexec",   1'b1, GOP,       6'b100010, 1'b1, e_r_exec(3'b100));
    cyc("sub_rwb",     1'b1, GOP,       GFN,       1'b1, e_r_wb());
    cyc("xor_fetch",   1'b1, GOP,       GFN,       1'b1, e_fetch(1'b1));
    cyc("xor_decode",  1'b1, 6'b000000, GFN,       1'b1, e_decode());
    cyc("xor_rexec",   1'b1, GOP,       6'b100110, 1'b1, e_r_exec(3'b010));
    cyc("xor_rwb",     1'b1, GOP,       GFN,       1'b1, e_r_wb());
    // lw with two wait cycles in MEM_RD: 7 cycles, mem_read held 3
    cyc("lw_fetch",    1'b1, GOP,       GFN,       1'b1, e_fetch(1'b1));
    cyc("lw_decode",   1'b1, 6'b100011, GFN,       1'b1, e_decode());
    cyc("lw_addr",     1'b0, GOP,       GFN,       1'b1, e_mem_addr());
    cyc("lw_rd_wait1", 1'b0, GOP,       GFN,       1'b1, e_mem_rd());
    cyc("lw_rd_wait2", 1'b0, GOP,       GFN,       1'b1, e_mem_rd());
    cyc("lw_rd_done",  1'b1, GOP,       GFN,       1'b1, e_mem_rd());
    cyc("lw_wb",       1'b1, GOP,       GFN,       1'b1, e_mem_wb());
    // sw with one FETCH wait cycle
    cyc("sw_fetch_w",  1'b0, GOP,       GFN,       1'b1, e_fetch(1'b0));
    cyc("sw_fetch",    1'b1, GOP,       GFN,       1'b1, e_fetch(1'b1));
    cyc("sw_decode",   1'b1, 6'b101011, GFN,       1'b1, e_decode());
    cyc("sw_addr",     1'b1, GOP,       GFN,       1'b1, e_mem_addr());
    cyc("sw_wr",       1'b1, GOP,       GFN,       1'b1, e_mem_wr());
    // beq taken, then not taken
    cyc("beq1_fetch",  1'b1, GOP,       GFN,       1'b0, e_fetch(1'b1));
    cyc("beq1_decode", 1'b1, 6'b000100, GFN,       1'b0, e_decode());
    cyc("beq1_branch", 1'b1, GOP,       GFN,       1'b1, e_branch(1'b1));
    cyc("beq0_fetch",  1'b1, GOP,       GFN,       1'b1, e_fetch(1'b1));
    cyc("beq0_decode", 1'b1, 6'b000100, GFN,       1'b1, e_decode());
    cyc("beq0_branch", 1'b1, GOP,       GFN,       1'b0, e_branch(1'b0));
    // I-type: opcode changes after DECODE must not affect I_EXEC
    cyc("lui_fetch",   1'b1, GOP,       GFN,       1'b1, e_fetch(1'b1));
    cyc("lui_decode",  1'b1, 6'b001111, GFN,       1'b1, e_decode());
    cyc("lui_iexec",   1'b1, 6'b000000, GFN,       1'b1, e_i_exec(3'b110, 2'b10));
    cyc("lui_iwb",     1'b1, GOP,       GFN,       1'b1, e_i_wb());
    cyc("andi_fetch",  1'b1, GOP,       GFN,       1'b1, e_fetch(1'b1));
    cyc("andi_decode", 1'b1, 6'b001100, GFN,       1'b1, e_decode());
    cyc("andi_iexec",  1'b1, 6'b001000, GFN,       1'b1, e_i_exec(3'b001, 2'b11));
    cyc("andi_iwb",    1'b1, GOP,       GFN,       1'b1, e_i_wb());
    cyc("ori_fetch",   1'b1, GOP,       GFN,       1'b1, e_fetch(1'b1));
    cyc("ori_decode",  1'b1, 6'b001101, GFN,       1'b1, e_decode());
    cyc("ori_iexec",   1'b1, GOP,       GFN,       1'b1, e_i_exec(3'b101, 2'b11));
    cyc("ori_iwb",     1'b1, GOP,       GFN,       1'b1, e_i_wb());
    cyc("addi_fetch",  1'b1, GOP,       GFN,       1'b1, e_fetch(1'b1));
    cyc("addi_decode", 1'b1, 6'b001000, GFN,       1'b1, e_decode());
    cyc("addi_iexec",  1'b1, 6'b001111, GFN,       1'b1, e_i_exec(3'b000, 2'b10));
    cyc("addi_iwb",    1'b1, GOP,       GFN,       1'b1, e_i_wb());
    // j
    cyc("j_fetch",     1'b1, GOP,       GFN,       1'b1, e_fetch(1'b1));
    cyc("j_decode",    1'b1, 6'b000010, GFN,       1'b1, e_decode());
    cyc("j_jump",      1'b1, GOP,       GFN,       1'b0, e_jump());
    // illegal opcode: HALT is absorbing, no writes
    cyc("badop_fetch", 1'b1, GOP,       GFN,       1'b1, e_fetch(1'b1));
    cyc("badop_dec",   1'b1, 6'b111111, GFN,       1'b1, e_decode());
    cyc("badop_halt1", 1'b1, 6'b000000, 6'b100000, 1'b1, e_halt());
    cyc("badop_halt2", 1'b1, 6'b101011, 6'b100000, 1'b1, e_halt());
    cyc("badop_halt3", 1'b1, 6'b000010, 6'b100000, 1'b1, e_halt());
    do_reset("badop_reset_clears");
    // R-type with unsupported funct
    cyc("badfn_fetch", 1'b1, GOP,       GFN,       1'b1, e_fetch(1'b1));
    cyc("badfn_dec",   1'b1, 6'b000000, 6'b100000, 1'b1, e_decode());
    cyc("badfn_rexec", 1'b1, GOP,       6'b000000, 1'b1, e_r_exec(3'b000));
    cyc("badfn_halt1", 1'b1, 6'b000000, 6'b100000, 1'b1, e_halt());
    cyc("badfn_halt2", 1'b1, 6'b100011, 6'b100000, 1'b1, e_halt());
    do_reset("badfn_reset_clears");
    // reset pulsed mid-MEM_WR while mem_write is high
    cyc("rsw_fetch",   1'b1, GOP,       GFN,       1'b1, e_fetch(1'b1));
    cyc("rsw_decode",  1'b1, 6'b101011, GFN,       1'b1, e_decode());
    cyc("rsw_addr",    1'b1, GOP,       GFN,       1'b1, e_mem_addr());
    begin
      sb_t e;
      bus.mem_ready = 1'b0;
      e.name = "rsw_wr_held";
      e.exp  = e_mem_wr();
      q.push_back(e);
      #5;
      rst_n = 1'b0;
      #1;
      check("rsw_async_reset", observed(), 23'h0);
      bus.mem_ready = 1'b1;
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
    end
    // first edge after reset evaluated FETCH with mem_ready=1
    cyc("rst_decode",  1'b1, 6'b000010, GFN,       1'b1, e_decode());
    cyc("rst_jump",    1'b1, GOP,       GFN,       1'b1, e_jump());
    cyc("rst_fetch",   1'b0, GOP,       GFN,       1'b1, e_fetch(1'b0));

    @(negedge clk);
    #1;
    check("scoreboard_drained", 23'(q.size()), 23'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 clk  in  1  single rising-edge clock for all state.
REQ-002 rst_n  in  1  reset, asynchronous assert, active-low; all flops clear on rst_n=0.
REQ-003 opcode  in  6  instruction[31:26]; sampled only in DECODE.
REQ-004 funct  in  6  instruction[5:0]; sampled only in R_EXEC.
REQ-005 zero  in  1  ALU zero flag; consumed only in BRANCH.
REQ-006 mem_ready  in  1  memory handshake; access completes in cycle mem_ready=1.
REQ-007 alu_op  out  3  ALU operation: 000 add, 100 sub, 001 and, 101 or, 010 xor, 110 lui.
REQ-008 alu_src_a  out  1  0=PC, 1=register A.
REQ-009 alu_src_b  out  2  00=register B, 01=constant 4, 10=sign-ext imm, 11=zero-ext imm.
REQ-010 pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, iord  out  1 each  datapath strobes/selects.
REQ-011 pc_src  out  2  00=ALU result, 01=ALU-out register, 10=jump target.
REQ-012 illegal  out  1  sticky flag: unsupported opcode/funct decoded.
REQ-013 state_dbg  out  4  current state encoding, for debug.

Function
REQ-014 Moore FSM; all outputs are a function of the registered state only, except pc_write_cond gating (REQ-022).
REQ-015 States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, HALT.
REQ-016 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000; on mem_ready=1 assert ir_write and pc_write and go to DECODE; otherwise hold FETCH with ir_write=pc_write=0.
REQ-017 DECODE: alu_src_a=0, alu_src_b=10, alu_op=000 (branch target precompute); next state from opcode: 000000->R_EXEC, 100011/101011->MEM_ADDR, 001000/001100/001101/001110/001111->I_EXEC, 000100->BRANCH, 000010->JUMP, any other->HALT with illegal set.
REQ-018 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000; next MEM_RD (lw) or MEM_WR (sw).
REQ-019 MEM_RD/MEM_WR: iord=1 with mem_read / mem_write held high until mem_ready=1; then MEM_RD->MEM_WB, MEM_WR->FETCH.
REQ-020 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-021 R_EXEC: alu_src_a=1, alu_src_b=00; funct 100000->000, 100010->100, 100100->001, 100101->101, 100110->010; next R_WB; any other funct -> HALT with illegal set, no write-back.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=100, pc_src=01, pc_write_cond=1; PC updates only when zero=1; next FETCH.
REQ-023 I_EXEC: alu_src_a=1; addi->alu_op 000, src_b 10; andi 001/11; ori 101/11; xori 010/11; lui 110/10; next I_WB.
REQ-024 R_WB / I_WB: reg_write=1, mem_to_reg=0, reg_dst=1 (R) / 0 (I); next FETCH.
REQ-025 JUMP: pc_write=1, pc_src=10; next FETCH.
REQ-026 HALT: all strobes 0; absorbing until reset; illegal stays 1.
REQ-027 Latency: R/I-type 4 cycles, beq 3, j 3, sw 4, lw 5, each plus one per mem_ready=0 wait cycle.
REQ-028 mem_read and mem_write never assert in the same cycle; write strobes never assert outside their listed states.
REQ-029 Inactive outputs: strobes 0, selects 0, alu_op 000.

Reset
REQ-030 rst_n=0 forces state FETCH, illegal=0, all strobes 0, immediately and independent of clk, including mid-access.
REQ-031 First rising clk edge after rst_n deasserts evaluates FETCH normally.

Structure
REQ-032 Shared package holds state enumeration, ALU op codes, opcode and funct constants, alu_src_b and pc_src encodings; the ALU and this block use the same ALU op constants.
REQ-033 One sub-module alu_op_decode (combinational opcode/funct -> alu_op, alu_src_b, legal); FSM registers in multicycle_ctrl.

Verification
REQ-034 add (op 000000, funct 100000), mem_ready=1 -> states FETCH,DECODE,R_EXEC(alu_op=000),R_WB(reg_write=1,reg_dst=1),FETCH; 4 cycles.
REQ-035 lw (100011), mem_ready low 2 cycles in MEM_RD -> mem_read held 3 cycles, MEM_WB mem_to_reg=1, total 7 cycles.
REQ-036 beq (000100) with zero=1 then zero=0 -> pc_write_cond=1 both times, alu_op=100; PC load observed only for zero=1.
REQ-037 lui (001111) -> I_EXEC alu_op=110, alu_src_b=10; I_WB reg_dst=0.
REQ-038 opcode 111111, then R-type funct 000000 -> HALT, illegal=1, no reg_write/mem_write thereafter until reset.
REQ-039 rst_n pulsed low mid-MEM_WR with mem_write=1 -> mem_write drops without clk edge; state_dbg=FETCH.
